// File: rtl/jk_mon_pkg.sv
// ---------------------------------------------------------------------------
// jk_mon_pkg
// Shared definitions for the JK consensus monitor and its voter.
//   mon_state_e : fault FSM state encoding (IDLE=0, MONITOR=1, SUSPECT=2, FAULT=3)
//   RUN_W       : width of the consecutive-mismatch run counter
// ---------------------------------------------------------------------------
package jk_mon_pkg;

   localparam int RUN_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MONITOR = 2'd1,
      SUSPECT = 2'd2,
      FAULT   = 2'd3
   } mon_state_e;

endpackage : jk_mon_pkg

// File: rtl/jk_majority3.sv
// ---------------------------------------------------------------------------
// jk_majority3
// Combinational 2-of-3 voter with a disagreement flag. Kept as its own block
// so sibling checkers can reuse the same voter.
// Ports:
//   a, b, c   in  1  the three redundant bits
//   maj       out 1  majority of a, b, c
//   disagree  out 1  high when the three bits are not all equal
// ---------------------------------------------------------------------------
module jk_majority3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic maj,
   output logic disagree
);

   assign maj      = (a & b) | (a & c) | (b & c);
   assign disagree = !((a == b) && (b == c));

endmodule : jk_majority3

// File: rtl/jk_consensus_monitor.sv
// ---------------------------------------------------------------------------
// jk_consensus_monitor
// Votes the Q outputs of three JK flip-flop implementations, flags any
// disagreement, counts mismatches and vote toggles, and runs a fault FSM
// whose FAULT state is sticky until clear_err.
// Optional feature macro: JK_MON_SOURCE_ID_EN adds err_src, the one-hot
// {sr,d,t} identity of the input that first disagreed with the majority.
// Ports:
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous active-high reset
//   valid_in      in   1      sample q_sr/q_d/q_t on this edge
//   q_sr,q_d,q_t  in   1      the three redundant Q bits
//   clear_err     in   1      synchronous clear of alarm, counters and run length
//   q_vote        out  1      registered majority
//   mismatch      out  1      pulse: last sample disagreed
//   mismatch_cnt  out  CNT_W  saturating mismatch count
//   toggle_cnt    out  CNT_W  wrapping count of q_vote changes
//   state         out  2      FSM state
//   alarm         out  1      high iff state is FAULT
//   err_src       out  3      (JK_MON_SOURCE_ID_EN only) first disagreeing source
// ---------------------------------------------------------------------------
module jk_consensus_monitor
   import jk_mon_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int FAIL_THRESH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             q_sr,
   input  logic             q_d,
   input  logic             q_t,
   input  logic             clear_err,
   output logic             q_vote,
   output logic             mismatch,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [1:0]       state,
   output logic             alarm
`ifdef JK_MON_SOURCE_ID_EN
   ,
   output logic [2:0]       err_src
`endif
);

   localparam logic [RUN_W-1:0] RUN_ONE_C = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] THRESH_C  = RUN_W'(FAIL_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             maj_s;
   logic             disagree_s;

   mon_state_e       state_r;
   mon_state_e       state_nxt_s;
   logic [RUN_W-1:0] run_r;
   logic [RUN_W-1:0] run_nxt_s;
   logic [RUN_W-1:0] run_inc_s;
   logic             q_vote_r;
   logic             q_vote_nxt_s;
   logic             mismatch_r;
   logic             mismatch_nxt_s;
   logic [CNT_W-1:0] mcnt_r;
   logic [CNT_W-1:0] mcnt_nxt_s;
   logic [CNT_W-1:0] tcnt_r;
   logic [CNT_W-1:0] tcnt_nxt_s;
   logic             alarm_r;

   jk_majority3 u_vote (
      .a        (q_sr),
      .b        (q_d),
      .c        (q_t),
      .maj      (maj_s),
      .disagree (disagree_s)
   );

   assign run_inc_s = run_r + RUN_ONE_C;

   // Next-state logic for the FSM, run length, vote and both counters.
   always_comb begin
      state_nxt_s    = state_r;
      run_nxt_s      = run_r;
      q_vote_nxt_s   = q_vote_r;
      mismatch_nxt_s = 1'b0;
      mcnt_nxt_s     = mcnt_r;
      tcnt_nxt_s     = tcnt_r;

      if (clear_err) begin
         // The sample on this edge is dropped; only a never-sampled monitor stays in IDLE.
         mcnt_nxt_s = '0;
         tcnt_nxt_s = '0;
         run_nxt_s  = '0;
         if (state_r == IDLE) begin
            state_nxt_s = IDLE;
         end else begin
            state_nxt_s = MONITOR;
         end
      end else if (valid_in) begin
         q_vote_nxt_s   = maj_s;
         mismatch_nxt_s = disagree_s;

         // The first sample out of IDLE only loads the vote; it is not a toggle.
         if ((state_r != IDLE) && (maj_s != q_vote_r)) begin
            tcnt_nxt_s = tcnt_r + CNT_ONE_C;
         end else begin
            tcnt_nxt_s = tcnt_r;
         end

         if (disagree_s && (mcnt_r != {CNT_W{1'b1}})) begin
            mcnt_nxt_s = mcnt_r + CNT_ONE_C;
         end else begin
            mcnt_nxt_s = mcnt_r;
         end

         case (state_r)
            IDLE, MONITOR: begin
               if (disagree_s) begin
                  run_nxt_s   = RUN_ONE_C;
                  state_nxt_s = (THRESH_C == RUN_ONE_C) ? FAULT : SUSPECT;
               end else begin
                  run_nxt_s   = '0;
                  state_nxt_s = MONITOR;
               end
            end
            SUSPECT: begin
               if (disagree_s) begin
                  run_nxt_s   = run_inc_s;
                  state_nxt_s = (run_inc_s == THRESH_C) ? FAULT : SUSPECT;
               end else begin
                  run_nxt_s   = '0;
                  state_nxt_s = MONITOR;
               end
            end
            FAULT: begin
               state_nxt_s = FAULT;
            end
            default: begin
               run_nxt_s   = '0;
               state_nxt_s = IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         run_r      <= '0;
         q_vote_r   <= 1'b0;
         mismatch_r <= 1'b0;
         mcnt_r     <= '0;
         tcnt_r     <= '0;
         alarm_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         run_r      <= run_nxt_s;
         q_vote_r   <= q_vote_nxt_s;
         mismatch_r <= mismatch_nxt_s;
         mcnt_r     <= mcnt_nxt_s;
         tcnt_r     <= tcnt_nxt_s;
         alarm_r    <= (state_nxt_s == FAULT);
      end
   end

   assign q_vote       = q_vote_r;
   assign mismatch     = mismatch_r;
   assign mismatch_cnt = mcnt_r;
   assign toggle_cnt   = tcnt_r;
   assign state        = state_r;
   assign alarm        = alarm_r;

`ifdef JK_MON_SOURCE_ID_EN
   logic [2:0] err_src_r;
   logic [2:0] err_src_nxt_s;

   // Latch the first disagreeing source; a nonzero value means already captured,
   // since any disagreement yields exactly one bit differing from the majority.
   always_comb begin
      err_src_nxt_s = err_src_r;
      if (clear_err) begin
         err_src_nxt_s = 3'b000;
      end else if (valid_in && disagree_s && (err_src_r == 3'b000)) begin
         err_src_nxt_s = {q_sr ^ maj_s, q_d ^ maj_s, q_t ^ maj_s};
      end else begin
         err_src_nxt_s = err_src_r;
      end
   end

   // Source-identity register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_src_r <= 3'b000;
      end else begin
         err_src_r <= err_src_nxt_s;
      end
   end

   assign err_src = err_src_r;
`endif

endmodule : jk_consensus_monitor

// File: tb/tb_jk_consensus_monitor.sv
module tb_jk_consensus_monitor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic valid_in = 1'b0;
   logic q_sr = 1'b0, q_d = 1'b0, q_t = 1'b0;
   logic clear_err = 1'b0;

   logic       vote0, mm0, alarm0;
   logic [7:0] mcnt0, tcnt0;
   logic [1:0] st0;
   logic       vote1, mm1, alarm1;
   logic [1:0] mcnt1, tcnt1;
   logic [1:0] st1;
`ifdef JK_MON_SOURCE_ID_EN
   logic [2:0] src0, src1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jk_consensus_monitor u_dut0 (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .q_sr(q_sr), .q_d(q_d), .q_t(q_t), .clear_err(clear_err),
      .q_vote(vote0), .mismatch(mm0), .mismatch_cnt(mcnt0), .toggle_cnt(tcnt0),
      .state(st0), .alarm(alarm0)
`ifdef JK_MON_SOURCE_ID_EN
      , .err_src(src0)
`endif
   );

   jk_consensus_monitor #(.CNT_W(2), .FAIL_THRESH(1)) u_dut1 (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .q_sr(q_sr), .q_d(q_d), .q_t(q_t), .clear_err(clear_err),
      .q_vote(vote1), .mismatch(mm1), .mismatch_cnt(mcnt1), .toggle_cnt(tcnt1),
      .state(st1), .alarm(alarm1)
`ifdef JK_MON_SOURCE_ID_EN
      , .err_src(src1)
`endif
   );

   // Reference model: one entry per DUT, written from the behavioural rules.
   typedef struct {
      bit seen;
      bit vote;
      int mcnt;
      int tcnt;
      int run;
      int st;
      bit mm;
      int src;
   } mdl_t;

   mdl_t m[2];
   int   cmax[2] = '{255, 3};
   int   thr[2]  = '{3, 1};

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < 2; k++) begin
         m[k].seen = 1'b0; m[k].vote = 1'b0; m[k].mcnt = 0; m[k].tcnt = 0;
         m[k].run = 0; m[k].st = 0; m[k].mm = 1'b0; m[k].src = 0;
      end
   endtask

   task automatic mdl_step();
      int ones;
      bit maj, dis;
      ones = int'(q_sr) + int'(q_d) + int'(q_t);
      maj  = (ones >= 2);
      dis  = (ones == 1) || (ones == 2);
      for (int k = 0; k < 2; k++) begin
         if (clear_err) begin
            m[k].mcnt = 0; m[k].tcnt = 0; m[k].run = 0; m[k].mm = 1'b0; m[k].src = 0;
            m[k].st = m[k].seen ? 1 : 0;
         end else if (valid_in) begin
            if (m[k].seen && (maj != m[k].vote))
               m[k].tcnt = (m[k].tcnt + 1) % (cmax[k] + 1);
            m[k].seen = 1'b1;
            m[k].vote = maj;
            m[k].mm   = dis;
            if (dis && m[k].mcnt < cmax[k]) m[k].mcnt++;
            if (dis && m[k].src == 0)
               m[k].src = (int'(q_sr != maj) << 2) | (int'(q_d != maj) << 1) | int'(q_t != maj);
            if (m[k].st != 3) begin
               if (dis) begin
                  m[k].run = (m[k].st == 2) ? m[k].run + 1 : 1;
                  m[k].st  = (m[k].run >= thr[k]) ? 3 : 2;
               end else begin
                  m[k].run = 0;
                  m[k].st  = 1;
               end
            end
         end else begin
            m[k].mm = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      check_eq("d0.q_vote", int'(vote0), int'(m[0].vote));
      check_eq("d0.mismatch", int'(mm0), int'(m[0].mm));
      check_eq("d0.mismatch_cnt", int'(mcnt0), m[0].mcnt);
      check_eq("d0.toggle_cnt", int'(tcnt0), m[0].tcnt);
      check_eq("d0.state", int'(st0), m[0].st);
      check_eq("d0.alarm", int'(alarm0), int'(m[0].st == 3));
      check_eq("d1.q_vote", int'(vote1), int'(m[1].vote));
      check_eq("d1.mismatch", int'(mm1), int'(m[1].mm));
      check_eq("d1.mismatch_cnt", int'(mcnt1), m[1].mcnt);
      check_eq("d1.toggle_cnt", int'(tcnt1), m[1].tcnt);
      check_eq("d1.state", int'(st1), m[1].st);
      check_eq("d1.alarm", int'(alarm1), int'(m[1].st == 3));
`ifdef JK_MON_SOURCE_ID_EN
      check_eq("d0.err_src", int'(src0), m[0].src);
      check_eq("d1.err_src", int'(src1), m[1].src);
`endif
   endtask

   task automatic do_cycle(input bit v, input bit [2:0] q, input bit clr);
      valid_in  = v;
      q_sr      = q[2];
      q_d       = q[1];
      q_t       = q[0];
      clear_err = clr;
      @(posedge clk);
      #1;
      mdl_step();
      check_all();
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      mdl_reset();
      check_all();
      #2 reset = 1'b0;
   endtask

   initial begin
      bit v0;
      bit [2:0] pat;
      mdl_reset();
      #12;
      check_all();
      reset = 1'b0;

      // 111,111,000: single toggle, no mismatch
      do_cycle(1'b1, 3'b111, 1'b0);
      do_cycle(1'b1, 3'b111, 1'b0);
      do_cycle(1'b1, 3'b000, 1'b0);
      check_eq("seqA.toggle_cnt", int'(tcnt0), 1);
      check_eq("seqA.state", int'(st0), 1);

      // Asynchronous reset with nonzero counters
      pulse_reset();
      check_eq("rst.toggle_cnt", int'(tcnt0), 0);
      check_eq("rst.state", int'(st0), 0);

      // 110 x3: SUSPECT, SUSPECT, FAULT on the threshold-3 monitor
      do_cycle(1'b1, 3'b110, 1'b0);
      do_cycle(1'b1, 3'b110, 1'b0);
      do_cycle(1'b1, 3'b110, 1'b0);
      check_eq("seqB.alarm", int'(alarm0), 1);
      check_eq("seqB.mismatch_cnt", int'(mcnt0), 3);
      check_eq("seqB.q_vote", int'(vote0), 1);
      do_cycle(1'b1, 3'b000, 1'b0);
      check_eq("seqB.sticky", int'(st0), 3);

      // clear_err wins over a disagreeing sample on the same edge
      do_cycle(1'b1, 3'b110, 1'b1);
      check_eq("clr.state", int'(st0), 1);
      check_eq("clr.mismatch", int'(mm0), 0);

      // 100,000,100: SUSPECT, MONITOR, SUSPECT
      do_cycle(1'b1, 3'b100, 1'b0);
      do_cycle(1'b1, 3'b000, 1'b0);
      do_cycle(1'b1, 3'b100, 1'b0);
      check_eq("seqC.state", int'(st0), 2);
      check_eq("seqC.mismatch_cnt", int'(mcnt0), 2);

      // Narrow counters: saturation and wrap
      do_cycle(1'b0, 3'b000, 1'b1);
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 3'b001, 1'b0);
      check_eq("sat.d1.mismatch_cnt", int'(mcnt1), 3);
      do_cycle(1'b0, 3'b000, 1'b1);
      v0 = vote1;
      for (int i = 0; i < 5; i++) begin
         pat = (((i % 2) == 0) ^ v0) ? 3'b111 : 3'b000;
         do_cycle(1'b1, pat, 1'b0);
      end
      check_eq("wrap.d1.toggle_cnt", int'(tcnt1), 1);

`ifdef JK_MON_SOURCE_ID_EN
      pulse_reset();
      do_cycle(1'b1, 3'b011, 1'b0);
      do_cycle(1'b1, 3'b101, 1'b0);
      check_eq("src.held", int'(src0), 4);
      do_cycle(1'b0, 3'b000, 1'b1);
      check_eq("src.clear", int'(src0), 0);
`endif

      // Randomized traffic against the model
      pulse_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset();
         do_cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 39) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_jk_consensus_monitor
